// File: rtl/uart_tx_outbox_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_outbox_pkg
// Shared definitions for the UART transmit outbox: the serial data width,
// the serializer state encoding and a byte type. The same values are used
// by UART receive-side logic, so they are kept in one place.
// ---------------------------------------------------------------------------
package uart_tx_outbox_pkg;

    // Payload bits per 8N1 frame
    localparam int DATA_W = 8;

    // Index of the last payload bit; after it the frame moves on to STOP
    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    // Serializer states (2-bit encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef logic [DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_outbox_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_tx_outbox_baud_tick
// Bit-period timer for the serializer. A down-counter that is loaded with
// CLOCKS_PER_BAUD-1 and raises o_tick on the cycle it reads 0, then reloads
// by itself, so o_tick repeats every CLOCKS_PER_BAUD cycles. i_load restarts
// the period so a new frame's start bit is always a full bit long.
//
// Ports
//   i_clk    in  1  system clock
//   i_rst_n  in  1  synchronous active-low reset
//   i_load   in  1  restart the bit period on the next cycle
//   o_tick   out 1  high on the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_tx_outbox_baud_tick #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;

    logic [23:0] cnt;

    assign o_tick = (cnt == 24'd0);

    // Reload on reset, on an explicit restart, or when the period expires;
    // otherwise count down. The counter never idles, which keeps the next
    // period aligned without any extra control.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load || o_tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 24'd1;
        end
    end

endmodule

// File: rtl/uart_tx_outbox.sv
// ---------------------------------------------------------------------------
// uart_tx_outbox
// Transmit outbox: a circular FIFO of bytes drained by a UART 8N1
// serializer onto o_uart_tx. Producers push single bytes with i_wr; the
// serializer pops whenever it is idle or finishing a stop bit, so queued
// bytes go out back-to-back with no idle gap. A registered dump port lets a
// display read any queued byte by its position relative to the oldest.
//
// Ports
//   i_clk        in   1       system clock
//   i_rst_n      in   1       synchronous active-low reset
//   i_wr         in   1       push strobe, one cycle per byte
//   i_data       in   8       byte to push
//   o_full       out  1       FIFO holds 2^LGFLEN entries
//   o_empty_n    out  1       FIFO holds at least one entry
//   o_overflow   out  1       one-cycle pulse: a push was dropped (FIFO full)
//   o_busy       out  1       serializer is sending START, DATA or STOP
//   o_uart_tx    out  1       serial line, idles high, driven from a flop
//   i_dmp_pos    in   LGFLEN  dump index, 0 = oldest queued byte
//   o_dmp_data   out  8       byte at i_dmp_pos (registered)
//   o_dmp_valid  out  1       i_dmp_pos < number of queued bytes (registered)
// ---------------------------------------------------------------------------
module uart_tx_outbox
    import uart_tx_outbox_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
    parameter int          LGFLEN          = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [7:0]        i_data,
    output logic              o_full,
    output logic              o_empty_n,
    output logic              o_overflow,
    output logic              o_busy,
    output logic              o_uart_tx,
    input  logic [LGFLEN-1:0] i_dmp_pos,
    output logic [7:0]        o_dmp_data,
    output logic              o_dmp_valid
);

    localparam int              DEPTH      = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_COUNT = (LGFLEN + 1)'(DEPTH);

    // FIFO storage and bookkeeping
    uart_byte_t        mem [DEPTH];
    logic [LGFLEN-1:0] head;
    logic [LGFLEN-1:0] tail;
    logic [LGFLEN:0]   count;
    logic              push;
    logic              pop;
    logic [LGFLEN-1:0] dmp_idx;

    // Serializer
    logic [1:0]        state;
    uart_byte_t        shift;
    logic [2:0]        bit_idx;
    logic              tx_q;
    logic              ovf_q;
    logic              baud_tick;

    // Fullness comes from the registered count, so a push that lands in the
    // same cycle as a pop on a full FIFO is still refused.
    assign o_full    = (count == FULL_COUNT);
    assign o_empty_n = (count != '0);
    assign push      = i_wr && !o_full;

    // A byte leaves the FIFO when the line is free: straight away from IDLE,
    // or on the final stop-bit cycle so the next start bit follows directly.
    assign pop = o_empty_n &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && baud_tick));

    assign o_busy     = (state != ST_IDLE);
    assign o_uart_tx  = tx_q;
    assign o_overflow = ovf_q;

    // Pointers are LGFLEN bits wide and wrap naturally around the buffer.
    assign dmp_idx = head + i_dmp_pos;

    uart_tx_outbox_baud_tick #(
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (pop),
        .o_tick  (baud_tick)
    );

    // FIFO control: pointers, occupancy and the drop indicator
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= i_wr && o_full;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write; contents need no reset because the pointers and
    // count define which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[tail] <= i_data;
        end
    end

    // Serializer control. o_uart_tx is registered and always set to the
    // value the line must carry during the following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            tx_q    <= 1'b1;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state   <= ST_START;
                        tx_q    <= 1'b0;
                        bit_idx <= '0;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state <= ST_DATA;
                        tx_q  <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            // shift[1] is the bit that becomes shift[0]
                            // after this period's shift
                            tx_q    <= shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (pop) begin
                            state   <= ST_START;
                            tx_q    <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    // Payload shift register, LSB first
    always_ff @(posedge i_clk) begin
        if (pop) begin
            shift <= mem[head];
        end else if ((state == ST_DATA) && baud_tick) begin
            shift <= shift >> 1;
        end
    end

    // Dump port: one-cycle registered view of the queue relative to head
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_dmp_data  <= '0;
            o_dmp_valid <= 1'b0;
        end else begin
            o_dmp_data  <= mem[dmp_idx];
            o_dmp_valid <= ({1'b0, i_dmp_pos} < count);
        end
    end

endmodule

// File: tb/tb_uart_tx_outbox.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_outbox
// Self-checking bench for uart_tx_outbox with CLOCKS_PER_BAUD=4, LGFLEN=5.
// Every output is logged one time unit after each rising edge. A reference
// model keeps the accepted bytes with their push cycle and predicts each
// frame's start cycle from the queueing rules; expected line, busy, FIFO
// flags and overflow pulses are derived from that list.
// ---------------------------------------------------------------------------
module tb_uart_tx_outbox;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 32;
    localparam int MAXC  = 16384;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] data;
    logic       full;
    logic       empty_n;
    logic       overflow;
    logic       busy;
    logic       uart_tx;
    logic [4:0] dmp_pos;
    logic [7:0] dmp_data;
    logic       dmp_valid;

    uart_tx_outbox #(
        .CLOCKS_PER_BAUD (24'd4),
        .LGFLEN          (5)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr        (wr),
        .i_data      (data),
        .o_full      (full),
        .o_empty_n   (empty_n),
        .o_overflow  (overflow),
        .o_busy      (busy),
        .o_uart_tx   (uart_tx),
        .i_dmp_pos   (dmp_pos),
        .o_dmp_data  (dmp_data),
        .o_dmp_valid (dmp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // log[j] = outputs just after rising edge number j
    logic tx_log   [MAXC];
    logic busy_log [MAXC];
    logic emp_log  [MAXC];
    logic full_log [MAXC];
    logic ovf_log  [MAXC];

    always begin
        @(posedge clk);
        #1;
        if (cyc < MAXC) begin
            tx_log[cyc]   = uart_tx;
            busy_log[cyc] = busy;
            emp_log[cyc]  = empty_n;
            full_log[cyc] = full;
            ovf_log[cyc]  = overflow;
        end
        cyc = cyc + 1;
    end

    // ---------------- reference model ----------------
    int         acc_t[$];   // edge that captured the push
    int         acc_s[$];   // first cycle of the start bit
    logic [7:0] acc_b[$];
    int         drop_t[$];

    task automatic model_clear();
        acc_t.delete();
        acc_s.delete();
        acc_b.delete();
        drop_t.delete();
    endtask

    // Queue occupancy just before edge t: earlier pushes minus earlier pops.
    // A byte is popped on the edge that begins its start bit.
    function automatic int occ_before(int t);
        int c = 0;
        foreach (acc_t[k]) if (acc_t[k] < t) c++;
        foreach (acc_s[k]) if (acc_s[k] < t) c--;
        return c;
    endfunction

    function automatic int occ_after(int j);
        int c = 0;
        foreach (acc_t[k]) if (acc_t[k] <= j) c++;
        foreach (acc_s[k]) if (acc_s[k] <= j) c--;
        return c;
    endfunction

    task automatic model_push(int t, logic [7:0] b);
        int s;
        if (occ_before(t) >= DEPTH) begin
            drop_t.push_back(t);
        end else begin
            s = t + 1;
            if (acc_s.size() > 0 && acc_s[acc_s.size()-1] + FRAME > s)
                s = acc_s[acc_s.size()-1] + FRAME;
            acc_t.push_back(t);
            acc_s.push_back(s);
            acc_b.push_back(b);
        end
    endtask

    function automatic logic exp_sig(int sig, int j);
        logic [7:0] b;
        int         bn;
        int         c;
        case (sig)
            0, 1: begin
                foreach (acc_s[k]) begin
                    if (j >= acc_s[k] && j < acc_s[k] + FRAME) begin
                        if (sig == 1) return 1'b1;
                        bn = (j - acc_s[k]) / CPB;
                        b  = acc_b[k];
                        if (bn == 0) return 1'b0;
                        if (bn == 9) return 1'b1;
                        return b[bn-1];
                    end
                end
                return (sig == 0) ? 1'b1 : 1'b0;
            end
            2: begin
                c = occ_after(j);
                return (c > 0);
            end
            3: begin
                c = occ_after(j);
                return (c == DEPTH);
            end
            default: begin
                foreach (drop_t[k]) if (drop_t[k] == j) return 1'b1;
                return 1'b0;
            end
        endcase
    endfunction

    function automatic logic got_sig(int sig, int j);
        case (sig)
            0:       return tx_log[j];
            1:       return busy_log[j];
            2:       return emp_log[j];
            3:       return full_log[j];
            default: return ovf_log[j];
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            0:       return "uart_tx";
            1:       return "busy";
            2:       return "empty_n";
            3:       return "full";
            default: return "overflow";
        endcase
    endfunction

    // Number of logged cycles in [from,to] where signal sig differs from the
    // model; the first differing cycle is reported through the outputs.
    function automatic int window_bad(input int sig, input int from, input int to,
                                      output int fj, output logic fg, output logic fw);
        int   nb = 0;
        logic g;
        logic w;
        fj = -1; fg = 1'b0; fw = 1'b0;
        for (int j = from; j <= to && j < MAXC; j++) begin
            g = got_sig(sig, j);
            w = exp_sig(sig, j);
            if (g !== w) begin
                if (nb == 0) begin fj = j; fg = g; fw = w; end
                nb++;
            end
        end
        return nb;
    endfunction

    // Expected dump result for a position applied before edge j
    function automatic logic exp_dump(input int j, input int pos, output logic [7:0] d);
        int n = 0;
        d = 8'h00;
        foreach (acc_t[k]) begin
            if (acc_t[k] < j && acc_s[k] >= j) begin
                if (n == pos) begin
                    d = acc_b[k];
                    return 1'b1;
                end
                n++;
            end
        end
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(logic [7:0] b);
        @(negedge clk);
        wr   = 1'b1;
        data = b;
        model_push(cyc, b);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            wr = 1'b0;
        end
    endtask

    // Drive a dump position and return after the registered result appears
    task automatic apply_dump(input int pos, output int j);
        @(negedge clk);
        wr      = 1'b0;
        dmp_pos = 5'(pos);
        j       = cyc;
        @(negedge clk);
    endtask

    // Idle until every modelled frame has finished; returns last logged cycle
    task automatic wait_drain(output int last);
        int endc;
        endc = cyc + 2;
        if (acc_s.size() > 0 && acc_s[acc_s.size()-1] + FRAME + 2 > endc)
            endc = acc_s[acc_s.size()-1] + FRAME + 2;
        while (cyc < endc + 1) begin
            @(negedge clk);
            wr = 1'b0;
        end
        last = endc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int   fj;
        logic fg;
        logic fw;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            wr   = 1'b1;
            data = 8'($urandom);
        end
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (empty_n !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty_n=%b full=%b want 0 0", empty_n, full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_cmp++; if (dmp_valid !== 1'b0 || dmp_data !== 8'h00) begin n_bad++; $display("FAIL reset_dump: valid=%b data=%h want 0 00", dmp_valid, dmp_data); end
        wr    = 1'b0;
        rst_n = 1'b1;
        model_clear();
        fj = cyc;
        idle(4);
        n_cmp++;
        if (window_bad(0, fj, cyc - 1, fj, fg, fw) != 0) begin
            n_bad++; $display("FAIL reset_idle_line: cycle %0d got %b want %b", fj, fg, fw);
        end
    endtask

    task automatic test_single();
        int   t0, last, nb, fj;
        logic fg, fw;
        push_byte(8'h55);
        t0 = cyc;
        idle(1);
        wait_drain(last);
        nb = 0;
        for (int j = t0 + 1; j <= t0 + FRAME; j++) nb += int'(busy_log[j]);
        n_cmp++; if (nb != 40 || busy_log[t0] !== 1'b0 || busy_log[t0+FRAME+1] !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_len: got %0d busy cycles want 40", nb);
        end
        n_cmp++; if (emp_log[t0] !== 1'b1 || emp_log[t0+1] !== 1'b0) begin
            n_bad++; $display("FAIL single_empty_n: got %b,%b want 1,0", emp_log[t0], emp_log[t0+1]);
        end
        n_cmp++; if (tx_log[t0] !== 1'b1 || tx_log[t0+1] !== 1'b0) begin
            n_bad++; $display("FAIL single_start_edge: got %b,%b want 1,0", tx_log[t0], tx_log[t0+1]);
        end
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0 - 1, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL single_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_back_to_back();
        int   t0, last, nb, fj;
        logic fg, fw;
        push_byte(8'h41);
        t0 = cyc;
        push_byte(8'h42);
        push_byte(8'h43);
        idle(1);
        wait_drain(last);
        nb = 0;
        for (int j = t0 + 1; j <= t0 + 3 * FRAME; j++) nb += int'(busy_log[j]);
        n_cmp++; if (nb != 120 || busy_log[t0+3*FRAME+1] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy_len: got %0d busy cycles want 120", nb);
        end
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0 - 1, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL b2b_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_overflow();
        int   t0, last, nb, fj, pulses, fulls;
        logic fg, fw;
        t0 = cyc + 1;
        for (int i = 0; i < 34; i++) push_byte(8'(i));
        idle(1);
        wait_drain(last);
        pulses = 0;
        fulls  = 0;
        for (int j = t0; j <= last; j++) begin
            pulses += int'(ovf_log[j]);
            fulls  += int'(full_log[j]);
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 1", pulses); end
        n_cmp++; if (fulls == 0) begin n_bad++; $display("FAIL ovf_full_seen: got 0 full cycles want >0"); end
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL ovf_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_dump();
        int         t0, j, last, nb, fj;
        logic       fg, fw, ev;
        logic [7:0] ed;
        push_byte(8'h41);
        t0 = cyc;
        push_byte(8'h42);
        push_byte(8'h43);
        for (int p = 0; p < 4; p++) begin
            apply_dump((p == 3) ? 31 : p, j);
            ev = exp_dump(j, (p == 3) ? 31 : p, ed);
            n_cmp++;
            if (dmp_valid !== ev || (ev && dmp_data !== ed)) begin
                n_bad++; $display("FAIL dump_pos%0d: got (%h,%b) want (%h,%b)", p, dmp_data, dmp_valid, ed, ev);
            end
        end
        wait_drain(last);
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0 - 1, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL dump_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_reset_midframe();
        int   t0, r, last, nb, fj;
        logic fg, fw;
        push_byte(8'hA5);
        t0 = cyc;
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        idle(1);
        while (cyc < acc_s[0] + 12) begin
            @(negedge clk);
            wr = 1'b0;
        end
        rst_n = 1'b0;
        r = cyc;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1 || busy !== 1'b0 || empty_n !== 1'b0) begin
            n_bad++; $display("FAIL midreset_state: tx=%b busy=%b empty_n=%b want 1 0 0", uart_tx, busy, empty_n);
        end
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0 - 1, r - 1, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL midreset_pre_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
        rst_n = 1'b1;
        model_clear();
        t0 = cyc;
        idle(2);
        push_byte(8'h7E);
        idle(1);
        wait_drain(last);
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL midreset_post_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_full_collision();
        int         t0, j, last, nb, fj, base;
        logic       fg, fw, ev;
        logic [7:0] ed;
        base = acc_s.size();
        t0 = cyc + 1;
        for (int i = 0; i < 33; i++) push_byte(8'(8'h80 + i));
        idle(1);
        while (cyc < acc_s[base+1] - 1) begin
            @(negedge clk);
            wr = 1'b0;
        end
        push_byte(8'hEE);
        idle(1);
        n_cmp++; if (overflow !== 1'b1 || full !== 1'b0) begin
            n_bad++; $display("FAIL collide_drop: overflow=%b full=%b want 1 0", overflow, full);
        end
        for (int p = 30; p <= 31; p++) begin
            apply_dump(p, j);
            ev = exp_dump(j, p, ed);
            n_cmp++;
            if (dmp_valid !== ev || dmp_valid !== (p == 30) || (ev && dmp_data !== ed)) begin
                n_bad++; $display("FAIL collide_dump%0d: got (%h,%b) want (%h,%b)", p, dmp_data, dmp_valid, ed, ev);
            end
        end
        wait_drain(last);
        for (int s = 0; s < 5; s++) begin
            n_cmp++;
            nb = window_bad(s, t0, last, fj, fg, fw);
            if (nb != 0) begin n_bad++; $display("FAIL collide_%s: %0d cycles differ, first %0d got %b want %b", sig_name(s), nb, fj, fg, fw); end
        end
    endtask

    task automatic test_random();
        int         t0, j, last, nb, fj, pos;
        logic       fg, fw, ev;
        logic [7:0] ed;
        for (int round = 0; round < 3; round++) begin
            t0 = cyc + 1;
            for (int i = 0; i < 10; i++) begin
                push_byte(8'($urandom));
                idle(int'($urandom_range(1, 50)));
                if ($urandom_range(0, 1) == 1) begin
                    pos = int'($urandom_range(0, 7));
                    apply_dump(pos, j);
                    ev = exp_dump(j, pos, ed);
                    n_cmp++;
                    if (dmp_valid !== ev || (ev && dmp_data !== ed)) begin
                        n_bad++; $display("FAIL rand_dump r%0d pos%0d: got (%h,%b) want (%h,%b)", round, pos, dmp_data, dmp_valid, ed, ev);
                    end
                end
            end
            wait_drain(last);
            for (int s = 0; s < 5; s++) begin
                n_cmp++;
                nb = window_bad(s, t0, last, fj, fg, fw);
                if (nb != 0) begin n_bad++; $display("FAIL rand_r%0d_%s: %0d cycles differ, first %0d got %b want %b", round, sig_name(s), nb, fj, fg, fw); end
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr      = 1'b0;
        data    = 8'h00;
        dmp_pos = 5'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_dump();
        test_reset_midframe();
        test_full_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
